// File: rtl/spcm_line_buffer.sv
// Single-line read buffer in front of spcm_core: serves Wishbone word reads from
// one buffered line and refills the whole line with a burst on a miss.
module spcm_line_buffer #(
    parameter int unsigned ADDR_BITS  = 24,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_cyc,
    input  logic                 wb_stb,
    input  logic                 wb_we,
    input  logic [ADDR_BITS-1:2] wb_addr,
    output logic [31:0]          wb_data_o,
    output logic                 wb_ack,
    output logic                 wb_err,
    input  logic                 inv,
    output logic                 core_cs,
    output logic [ADDR_BITS-1:2] core_addr,
    output logic                 core_burst,
    input  logic [31:0]          core_dout,
    input  logic                 core_busy,
    input  logic                 core_ack
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned TAG_W = ADDR_BITS - 2 - OFF_W;
    localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]       state, state_n;
    logic [OFF_W-1:0] cnt, cnt_n;
    logic             valid, valid_n;
    logic [TAG_W-1:0] tag, tag_n;
    logic [TAG_W-1:0] req_tag, req_tag_n;
    logic [OFF_W-1:0] req_off, req_off_n;
    logic             inv_seen, inv_seen_n;
    logic             dropped, dropped_n;
    logic             ack_n, err_n, cs_n, burst_n;
    logic [31:0]      data_n;
    logic [ADDR_BITS-1:2] addr_n;

    logic [31:0] line_mem [LINE_WORDS];

    logic [TAG_W-1:0] wb_tag_c;
    logic [OFF_W-1:0] wb_off_c;
    logic             req_c;
    logic             hit_c;
    logic             fill_we_c;

    // A request is ignored in the cycle its ack/err is still showing
    assign wb_tag_c  = wb_addr[ADDR_BITS-1:OFF_W+2];
    assign wb_off_c  = wb_addr[OFF_W+1:2];
    assign req_c     = wb_cyc & wb_stb & ~wb_ack & ~wb_err;
    assign hit_c     = valid & (wb_tag_c == tag);
    assign fill_we_c = (state == S_FILL) & core_ack;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        valid_n    = valid & ~inv;
        tag_n      = tag;
        req_tag_n  = req_tag;
        req_off_n  = req_off;
        inv_seen_n = inv_seen | inv;
        dropped_n  = dropped;
        ack_n      = 1'b0;
        err_n      = 1'b0;
        data_n     = 32'd0;
        cs_n       = core_cs;
        addr_n     = core_addr;

        case (state)
            S_IDLE: begin
                if (req_c) begin
                    if (wb_we) begin
                        err_n = 1'b1;
                    end else if (hit_c) begin
                        ack_n  = 1'b1;
                        data_n = line_mem[wb_off_c];
                    end else begin
                        req_tag_n  = wb_tag_c;
                        req_off_n  = wb_off_c;
                        valid_n    = 1'b0;
                        inv_seen_n = 1'b0;
                        dropped_n  = 1'b0;
                        cnt_n      = '0;
                        cs_n       = 1'b1;
                        addr_n     = {wb_tag_c, OFF_W'(0)};
                        state_n    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                dropped_n = dropped | ~wb_cyc;
                if (core_busy) begin
                    cs_n    = 1'b0;
                    state_n = S_FILL;
                end
            end
            S_FILL: begin
                // The core cannot abort a burst, so an abandoned request still fills
                dropped_n = dropped | ~wb_cyc;
                if (core_ack) begin
                    cnt_n = cnt + OFF_W'(1);
                    if (cnt == LAST) begin
                        tag_n   = req_tag;
                        valid_n = ~(inv_seen | inv);
                        state_n = S_RESP;
                    end
                end
            end
            default: begin
                if (wb_cyc & wb_stb & ~dropped) begin
                    ack_n  = 1'b1;
                    data_n = line_mem[req_off];
                end
                state_n = S_IDLE;
            end
        endcase

        burst_n = ((state_n == S_REQ) | (state_n == S_FILL)) & (cnt_n != LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            valid      <= 1'b0;
            tag        <= '0;
            req_tag    <= '0;
            req_off    <= '0;
            inv_seen   <= 1'b0;
            dropped    <= 1'b0;
            wb_ack     <= 1'b0;
            wb_err     <= 1'b0;
            wb_data_o  <= 32'd0;
            core_cs    <= 1'b0;
            core_addr  <= '0;
            core_burst <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            valid      <= valid_n;
            tag        <= tag_n;
            req_tag    <= req_tag_n;
            req_off    <= req_off_n;
            inv_seen   <= inv_seen_n;
            dropped    <= dropped_n;
            wb_ack     <= ack_n;
            wb_err     <= err_n;
            wb_data_o  <= data_n;
            core_cs    <= cs_n;
            core_addr  <= addr_n;
            core_burst <= burst_n;
        end
    end

    // Line storage; a partial fill is discarded through the valid bit alone
    always_ff @(posedge clk) begin
        if (fill_we_c) begin
            line_mem[cnt] <= core_dout;
        end
    end

endmodule

// File: tb/tb_spcm_line_buffer.sv
// Self-checking bench for spcm_line_buffer: behavioural spcm_core model, a
// one-line reference model, a directed vector table, corner sequences, random reads.
module tb_spcm_line_buffer;

    localparam int unsigned AB = 24;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_cyc, wb_stb, wb_we, inv;
    logic [AB-1:2] wb_addr;
    logic [31:0]   wb_data_o;
    logic          wb_ack, wb_err;
    logic          core_cs, core_burst;
    logic [AB-1:2] core_addr;
    logic [31:0]   core_dout;
    logic          core_busy, core_ack;

    spcm_line_buffer #(.ADDR_BITS(AB), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data_o(wb_data_o), .wb_ack(wb_ack), .wb_err(wb_err), .inv(inv),
        .core_cs(core_cs), .core_addr(core_addr), .core_burst(core_burst),
        .core_dout(core_dout), .core_busy(core_busy), .core_ack(core_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [0:1023];

    // reference model of the buffered line
    bit          m_valid = 1'b0;
    int unsigned m_tag   = 0;

    // core model bookkeeping
    int          cs_count  = 0;
    int          ack_total = 0;
    int unsigned cs_addr_seen = 0;

    typedef struct {
        int unsigned addr;
        bit          we;
        bit          pre_inv;
        bit          exp_fill;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural spcm_core: accept core_cs, go busy, stream words until burst low
    initial begin : core_model
        bit active, finishing;
        int delay, idx;
        int unsigned ptr;
        active = 0; finishing = 0; delay = 0; idx = 0; ptr = 0;
        core_busy = 1'b0; core_ack = 1'b0; core_dout = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0; finishing = 0; core_busy = 1'b0; core_ack = 1'b0;
            end else if (finishing) begin
                core_ack = 1'b0; core_busy = 1'b0; active = 0; finishing = 0;
            end else if (!active) begin
                core_ack = 1'b0;
                if (core_cs) begin
                    active = 1; core_busy = 1'b1; cs_count++;
                    cs_addr_seen = int'(core_addr);
                    ptr = int'(core_addr); idx = 0;
                    delay = int'($urandom_range(2, 1));
                end
            end else if (delay > 0) begin
                core_ack = 1'b0; delay--;
            end else begin
                core_ack  = 1'b1;
                core_dout = mem[ptr % 1024];
                ptr++; ack_total++;
                check("core_burst", 64'(core_burst), 64'(idx < int'(LW) - 1));
                if (!core_burst || idx >= int'(LW) - 1) finishing = 1;
                else delay = int'($urandom_range(1, 0));
                idx++;
            end
        end
    end

    task automatic wait_core_acks(input int target);
        int n;
        n = 0;
        while (ack_total < target && n < 300) begin
            @(negedge clk); #1; n++;
        end
        check("core_ack_wait", 64'(ack_total >= target), 64'(1));
    endtask

    // One Wishbone transaction, checked against the reference model
    task automatic txn(input int unsigned a, input bit we, input bit pre_inv, input bit exp_fill);
        int cs0, cyc;
        bit got, both, nz;
        if (pre_inv) begin
            inv = 1'b1; @(negedge clk); inv = 1'b0; m_valid = 0;
        end
        cs0 = cs_count; cyc = 0; got = 0; both = 0; nz = 0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = 22'(a);
        while (!got && cyc < 300) begin
            @(negedge clk); cyc++;
            if (wb_ack && wb_err) both = 1;
            if (!wb_ack && wb_data_o != 32'd0) nz = 1;
            if (wb_ack || wb_err) got = 1;
        end
        check("response_seen", 64'(got), 64'(1));
        check("ack_err_exclusive_or_data_zero", 64'({both, nz}), 64'(0));
        if (we) begin
            check("write_err", 64'({wb_err, wb_ack}), 64'(2'b10));
            check("write_latency", 64'(cyc), 64'(1));
            check("write_no_core", 64'(cs_count - cs0), 64'(0));
        end else begin
            check("read_ack", 64'({wb_ack, wb_err}), 64'(2'b10));
            check("read_data", 64'(wb_data_o), 64'(mem[a % 1024]));
            check("read_fill_count", 64'(cs_count - cs0), 64'(exp_fill));
            if (exp_fill) check("fill_addr", 64'(cs_addr_seen), 64'(a & ~(LW - 1)));
            else          check("hit_latency", 64'(cyc), 64'(1));
            m_valid = 1; m_tag = a / LW;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        check("err_single_cycle", 64'({wb_err, wb_ack}), 64'(0));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_bad %0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs [12];
        int cs0, acks, t;
        bit nz;

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        vecs[0]  = '{addr: 32'h13,  we: 0, pre_inv: 0, exp_fill: 1};
        vecs[1]  = '{addr: 32'h17,  we: 0, pre_inv: 0, exp_fill: 0};
        vecs[2]  = '{addr: 32'h17,  we: 1, pre_inv: 0, exp_fill: 0};
        vecs[3]  = '{addr: 32'h10,  we: 0, pre_inv: 0, exp_fill: 0};
        vecs[4]  = '{addr: 32'h11,  we: 0, pre_inv: 1, exp_fill: 1};
        vecs[5]  = '{addr: 32'h2A,  we: 0, pre_inv: 0, exp_fill: 1};
        vecs[6]  = '{addr: 32'h28,  we: 0, pre_inv: 0, exp_fill: 0};
        vecs[7]  = '{addr: 32'h1F,  we: 0, pre_inv: 0, exp_fill: 1};
        vecs[8]  = '{addr: 32'h00,  we: 1, pre_inv: 0, exp_fill: 0};
        vecs[9]  = '{addr: 32'h18,  we: 0, pre_inv: 0, exp_fill: 0};
        vecs[10] = '{addr: 32'h3FF, we: 0, pre_inv: 0, exp_fill: 1};
        vecs[11] = '{addr: 32'h3F8, we: 0, pre_inv: 0, exp_fill: 0};

        rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = '0; inv = 1'b0;
        #1;
        check("reset_outputs", 64'({wb_ack, wb_err, core_cs, core_burst, wb_data_o, core_addr}), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) txn(vecs[i].addr, vecs[i].we, vecs[i].pre_inv, vecs[i].exp_fill);

        // inv during a fill: request still acked, line not kept
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 22'(32'h43);
        wait_core_acks(ack_total + 2);
        inv = 1'b1; @(negedge clk); #1; inv = 1'b0;
        t = 0;
        while (!wb_ack && t < 300) begin @(negedge clk); t++; end
        check("inv_fill_ack", 64'(wb_ack), 64'(1));
        check("inv_fill_data", 64'(wb_data_o), 64'(mem[32'h43]));
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        m_valid = 0;
        txn(32'h45, 0, 0, 1);

        // cyc dropped after 3rd core ack: fill completes silently, line kept
        cs0 = cs_count;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_addr = 22'(32'h31);
        wait_core_acks(ack_total + 3);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        acks = 0;
        for (int i = 0; i < 30; i++) begin @(negedge clk); if (wb_ack) acks++; end
        check("dropped_no_ack", 64'(acks), 64'(0));
        check("dropped_one_fill", 64'(cs_count - cs0), 64'(1));
        m_valid = 1; m_tag = 32'h31 / LW;
        txn(32'h37, 0, 0, 0);

        // inv coincident with a hit: hit acked, then line invalid
        inv = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1; wb_addr = 22'(32'h35);
        @(negedge clk);
        inv = 1'b0;
        check("inv_hit_ack", 64'({wb_ack, wb_err}), 64'(2'b10));
        check("inv_hit_data", 64'(wb_data_o), 64'(mem[32'h35]));
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        m_valid = 0;
        txn(32'h36, 0, 0, 1);

        // reset after the 5th core ack of a fill
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_addr = 22'(32'h51);
        wait_core_acks(ack_total + 5);
        rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        #1;
        check("midfill_reset_outputs", 64'({wb_ack, wb_err, core_cs, core_burst, wb_data_o, core_addr}), 64'(0));
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        m_valid = 0;
        txn(32'h51, 0, 0, 1);
        txn(32'h56, 0, 0, 0);

        // random traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            int unsigned a;
            bit we, pi, fill;
            a  = ($urandom_range(5, 0) * LW) + $urandom_range(LW - 1, 0);
            we = ($urandom_range(4, 0) == 0);
            pi = ($urandom_range(5, 0) == 0);
            fill = pi || !(m_valid && m_tag == a / LW);
            txn(a, we, pi, fill);
        end

        nz = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wb_ack || wb_err || core_cs || wb_data_o != 32'd0) nz = 1;
        end
        check("quiet_idle", 64'(nz), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spcm_line_buffer.md
SPCM_LINE_BUFFER -- requirements
Module: spcm_line_buffer

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 24, meaning the serial PCM byte-address width, matching the downstream spcm_core.
REQ-002 SHALL have parameter LINE_WORDS, default 8, meaning the 32-bit words per buffered line (power of 2, 2..32).
REQ-003 SHALL have port clk, input, 1, main clock.
REQ-004 SHALL have port rst_n, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port wb_cyc, input, 1, bus cycle valid.
REQ-006 SHALL have port wb_stb, input, 1, strobe.
REQ-007 SHALL have port wb_we, input, 1, write enable.
REQ-008 SHALL have port wb_addr, input, ADDR_BITS-2 (bits ADDR_BITS-1:2), word address.
REQ-009 SHALL have port wb_data_o, output, 32, read data.
REQ-010 SHALL have port wb_ack, output, 1, read acknowledge.
REQ-011 SHALL have port wb_err, output, 1, error acknowledge.
REQ-012 SHALL have port inv, input, 1, invalidate the buffered line.
REQ-013 SHALL have port core_cs, output, 1, request to spcm_core.
REQ-014 SHALL have port core_addr, output, ADDR_BITS-2, start word address to spcm_core.
REQ-015 SHALL have port core_burst, output, 1, continue-burst flag to spcm_core.
REQ-016 SHALL have port core_dout, input, 32, word returned by spcm_core.
REQ-017 SHALL have port core_busy, input, 1, spcm_core busy.
REQ-018 SHALL have port core_ack, input, 1, spcm_core word-valid pulse.

Function
REQ-019 SHALL hold one line: LINE_WORDS x 32-bit data, a tag register (wb_addr bits above the line offset) and a valid bit.
REQ-020 SHALL run states IDLE, REQ, FILL, RESP.
REQ-021 IDLE: a request is wb_cyc & wb_stb; on a write, SHALL pulse wb_err for one cycle on the next clock and stay in IDLE.
REQ-022 IDLE, read hit (valid & tag match): SHALL pulse wb_ack one cycle on the next clock, with wb_data_o = the buffered word at the offset (1-cycle latency).
REQ-023 IDLE, read miss: SHALL capture the line-aligned address, clear valid, and go to REQ.
REQ-024 REQ: SHALL drive core_cs=1 and core_addr = the aligned address, holding until core_busy=1, then go to FILL with core_cs=0.
REQ-025 FILL: on each core_ack, SHALL write core_dout to the entry at the word counter (0..LINE_WORDS-1) and increment the counter.
REQ-026 core_burst SHALL be 1 in REQ/FILL while counter < LINE_WORDS-1, and 0 when counter = LINE_WORDS-1, so the core stops after exactly LINE_WORDS words.
REQ-027 On the last core_ack, SHALL set the tag, set valid (unless inv was seen during the fill) and go to RESP.
REQ-028 RESP: SHALL pulse wb_ack one cycle with the requested word if wb_cyc & wb_stb are still high, then go to IDLE.
REQ-029 If wb_cyc drops mid-fill, the fill SHALL complete (the core cannot abort), no ack SHALL be issued, and the line SHALL be kept.
REQ-030 After any ack or err, the next request SHALL be evaluated no earlier than the following cycle; wb_ack and wb_err SHALL never be high together.
REQ-031 inv in IDLE SHALL clear valid next clock; inv coincident with a hit SHALL still ack that hit, then clear valid.
REQ-032 wb_data_o SHALL be 0 whenever wb_ack=0.

Reset
REQ-033 While rst_n=0, asynchronously: state=IDLE, valid=0, counter=0, tag=0; outputs wb_ack, wb_err, core_cs, core_burst =0; wb_data_o, core_addr =0.
REQ-034 A reset mid-fill SHALL discard the partial line; the system SHALL drive the spcm_core reset from ~rst_n so that both blocks restart together.

Verification
REQ-035 Cold read of word addr 0x000013 (LINE_WORDS=8) -> one core_cs pulse with core_addr 0x000010, 8 core_acks, core_burst low only during the 8th, wb_ack with the 4th word.
REQ-036 Read of 0x000017 after REQ-035 -> wb_ack exactly 1 cycle after the strobe, no core_cs.
REQ-037 Write strobe to any address -> one-cycle wb_err, no wb_ack, no core activity.
REQ-038 inv pulse, then read of 0x000011 -> full refill and ack; inv asserted during a fill -> request acked, next read of the same line misses.
REQ-039 wb_cyc dropped after the 3rd core_ack -> fill completes, no ack, subsequent read of the same line hits in 1 cycle.
REQ-040 rst_n low after the 5th core_ack -> outputs zero immediately, valid=0; next read refills from word 0.
